// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank with byte strobes and read-only slots fed from ro_in.
// Register contents and per-register write strobes are exported to fabric logic.
module axi4_lite_regbank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_AW,
        HAVE_W,
        RESP
    } wr_state_t;

    wr_state_t state, state_next;

    logic                  aw_held;
    logic                  w_held;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [NUM_REGS-1:0]   wr_sel;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic                  unused_bits;

    assign aw_held = (state == HAVE_AW);
    assign w_held  = (state == HAVE_W);
    assign BVALID  = (state == RESP);
    assign AWREADY = !aw_held && !BVALID;
    assign WREADY  = !w_held && !BVALID;
    assign ARREADY = !rvalid_q;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Commit fires on whichever edge completes the second of the AW/W handshakes.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else if (aw_hs) begin
                    state_next = HAVE_AW;
                end else if (w_hs) begin
                    state_next = HAVE_W;
                end
            end
            HAVE_AW: begin
                if (w_hs) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            HAVE_W: begin
                if (aw_hs) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (BREADY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Use the live bus value for whichever half is handshaking on the commit edge.
    assign wr_addr = aw_hs ? AWADDR : awaddr_q;
    assign wr_data = w_hs ? WDATA : wdata_q;
    assign wr_strb = w_hs ? WSTRB : wstrb_q;
    assign wr_idx  = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx  = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = commit && (wr_idx == IDX_W'(i)) && !RO_MASK[i];
        end
    end

    assign wr_ok = |wr_sel;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (wr_sel[i] && wr_strb[k]) begin
                        regs[i][k*8 +: 8] <= wr_data[k*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
        end else begin
            if (aw_hs) begin
                awaddr_q <= AWADDR;
            end
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (commit) begin
                bresp_q <= wr_ok ? 2'b00 : 2'b10;
            end
            wr_pulse_q <= wr_sel;
        end
    end

    // Out-of-range index keeps rd_err set and data zero.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_err  = 1'b0;
                rd_data = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? 2'b10 : 2'b00;
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign BRESP    = bresp_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    // ro_in slices of writable registers and sub-word address bits are intentionally ignored.
    assign unused_bits = ^{ro_in, wr_addr[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

endmodule
